// File: rtl/rgb_pwm_driver_if.sv
// Command channel from the colour sequencer (master) to the RGB PWM driver (slave).
// A command moves across when cmd_valid and cmd_ready are both high at a clock edge.
interface rgb_pwm_driver_if #(
    parameter int PWM_BITS = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_led;
    logic [2:0]          cmd_color;
    logic [PWM_BITS-1:0] cmd_level;

    modport master (
        output cmd_valid,
        output cmd_led,
        output cmd_color,
        output cmd_level,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_led,
        input  cmd_color,
        input  cmd_level,
        output cmd_ready
    );
endinterface

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: takes colour/brightness commands over a valid/ready channel and
// drives two RGB LEDs with per-LED dimmed PWM. An accepted command sits in a pending
// buffer and only reaches the active registers at a PWM period boundary, so no
// period is ever emitted with a half-old, half-new setting.
module rgb_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 392
) (
    input  logic            clock,
    input  logic            reset,
    rgb_pwm_driver_if.slave cmd,
    output logic [2:0]      RGB1,
    output logic [2:0]      RGB2,
    output logic            period_start
);

    // PRESCALE of 1 still needs a one-bit prescaler; it simply never leaves 0.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    // The PWM counter stops one short of all-ones, so the maximum level is
    // strictly greater than every count and yields a constant-on output.
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step;
    logic                boundary;
    logic                running;

    logic                ready;
    logic                load_pending;
    logic                apply_pending;

    logic [1:0]          pend_led;
    logic [2:0]          pend_color;
    logic [PWM_BITS-1:0] pend_level;

    logic [2:0]          active_color1;
    logic [PWM_BITS-1:0] active_level1;
    logic [2:0]          active_color2;
    logic [PWM_BITS-1:0] active_level2;

    assign step     = (prescaler == PS_LAST);
    assign boundary = step && (pwm_cnt == CNT_LAST);

    assign cmd.cmd_ready = ready;

    // Timebase: prescaler divides the clock into PWM steps, pwm_cnt walks one period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (step) begin
            prescaler <= '0;
            pwm_cnt   <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Period marker lags the boundary by one cycle so it lines up with pwm_cnt == 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
        end
    end

    // Holds cmd_ready low for every cycle reset is asserted; the FSM alone would
    // already read IDLE after the first reset edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // Command FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command FSM next state: accept while idle, then wait for a boundary to commit.
    // IDLE never applies, so a command accepted on a boundary cycle waits a full period.
    always_comb begin
        state_next    = state;
        ready         = 1'b0;
        load_pending  = 1'b0;
        apply_pending = 1'b0;
        case (state)
            IDLE: begin
                ready = running;
                if (running && cmd.cmd_valid && (cmd.cmd_led != 2'b00)) begin
                    load_pending = 1'b1;
                    state_next   = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    apply_pending = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending buffer captures the accepted command until the next boundary.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_led   <= 2'b00;
            pend_color <= 3'b000;
            pend_level <= '0;
        end else if (load_pending) begin
            pend_led   <= cmd.cmd_led;
            pend_color <= cmd.cmd_color;
            pend_level <= cmd.cmd_level;
        end
    end

    // Active settings for LED 1 change only at a boundary and only when selected.
    always_ff @(posedge clock) begin
        if (!reset) begin
            active_color1 <= 3'b000;
            active_level1 <= '0;
        end else if (apply_pending && pend_led[0]) begin
            active_color1 <= pend_color;
            active_level1 <= pend_level;
        end
    end

    // Active settings for LED 2 change only at a boundary and only when selected.
    always_ff @(posedge clock) begin
        if (!reset) begin
            active_color2 <= 3'b000;
            active_level2 <= '0;
        end else if (apply_pending && pend_led[1]) begin
            active_color2 <= pend_color;
            active_level2 <= pend_level;
        end
    end

    // Registered pin drive: a channel is lit while the count is below its LED's level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            RGB1 <= 3'b000;
            RGB2 <= 3'b000;
        end else begin
            RGB1 <= active_color1 & {3{pwm_cnt < active_level1}};
            RGB2 <= active_color2 & {3{pwm_cnt < active_level2}};
        end
    end

endmodule
